// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between an instruction-fetch port and a data port.
// Data has priority, and a starvation counter force-grants fetch after STARVE_MAX consecutive denials.
module sram_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic [DATA_W/8-1:0] data_wen,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                sram_en,
   output logic [DATA_W/8-1:0] sram_wen,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);

   localparam int WEN_W = DATA_W / 8;
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

   owner_t            grant_p0;
   owner_t            resp_owner;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_cnt_nxt;
   logic              force_inst;
   logic [DATA_W-1:0] inst_hold_p1;
   logic [DATA_W-1:0] data_hold_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == STARVE_LIM) ? v : v + CNT_W'(1);
   endfunction

   // Stage 0: combinational grant; resetn is active-high, so nothing is granted while it is asserted.
   always_comb begin
      grant_p0       = OWN_NONE;
      starve_cnt_nxt = '0;
      force_inst     = inst_req && (starve_cnt == STARVE_LIM);
      if (resetn)
         grant_p0 = OWN_NONE;
      else if (force_inst)
         grant_p0 = OWN_INST;
      else if (data_req)
         grant_p0 = OWN_DATA;
      else if (inst_req)
         grant_p0 = OWN_INST;
      if (inst_req && grant_p0 != OWN_INST)
         starve_cnt_nxt = sat_inc(starve_cnt);
   end

   assign inst_addr_ok = (grant_p0 == OWN_INST);
   assign data_addr_ok = (grant_p0 == OWN_DATA);
   assign sram_en      = (grant_p0 != OWN_NONE);
   assign sram_addr    = (grant_p0 == OWN_DATA) ? data_addr :
                         (grant_p0 == OWN_INST) ? inst_addr : '0;
   assign sram_wen     = (grant_p0 == OWN_DATA) ? data_wen   : WEN_W'(0);
   assign sram_wdata   = (grant_p0 == OWN_DATA) ? data_wdata : '0;

   // Stage 1: response ownership; the read data holds are cleared too so every output is 0 in reset.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         resp_owner   <= OWN_NONE;
         starve_cnt   <= '0;
         inst_hold_p1 <= '0;
         data_hold_p1 <= '0;
      end else begin
         resp_owner <= grant_p0;
         starve_cnt <= starve_cnt_nxt;
         if (resp_owner == OWN_INST)
            inst_hold_p1 <= sram_rdata;
         if (resp_owner == OWN_DATA)
            data_hold_p1 <= sram_rdata;
      end
   end

   assign inst_data_ok = (resp_owner == OWN_INST);
   assign data_data_ok = (resp_owner == OWN_DATA);
   assign inst_rdata   = inst_data_ok ? sram_rdata : inst_hold_p1;
   assign data_rdata   = data_data_ok ? sram_rdata : data_hold_p1;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small byte-writable synchronous SRAM model.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:1023];
   logic [9:0]  widx;

   always #5 clk = ~clk;

   sram_port_arbiter dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // Synchronous SRAM: read data appears the cycle after sram_en, writes are byte-masked.
   assign widx = sram_addr[11:2];
   always @(posedge clk) begin
      if (sram_en) begin
         sram_rdata <= mem[widx];
         for (int b = 0; b < 4; b++)
            if (sram_wen[b]) mem[widx][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      inst_req = 1'b0; data_req = 1'b0; data_wen = 4'h0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | (i << 2);
      sram_rdata = 32'h0;
      resetn = 1'b1;
      idle();
      inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;

      // Reset: requests present but nothing granted
      @(negedge clk); inst_req = 1'b1; data_req = 1'b1; data_wen = 4'hF;
      @(negedge clk); #1;
      chk("rst_sram_en", {31'b0, sram_en}, 32'h0);
      chk("rst_sram_wen", {28'b0, sram_wen}, 32'h0);
      chk("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
      chk("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'h0);
      chk("rst_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
      chk("rst_data_data_ok", {31'b0, data_data_ok}, 32'h0);
      idle();
      @(negedge clk); resetn = 1'b0;

      // Fetch only
      @(negedge clk); inst_req = 1'b1; inst_addr = 32'h100; #1;
      chk("f_addr_ok", {31'b0, inst_addr_ok}, 32'h1);
      chk("f_sram_en", {31'b0, sram_en}, 32'h1);
      chk("f_sram_addr", sram_addr, 32'h100);
      chk("f_sram_wen", {28'b0, sram_wen}, 32'h0);
      chk("f_data_addr_ok", {31'b0, data_addr_ok}, 32'h0);
      @(negedge clk); idle(); #1;
      chk("f_data_ok", {31'b0, inst_data_ok}, 32'h1);
      chk("f_rdata", inst_rdata, 32'hC0DE_0100);
      chk("f_no_dd_ok", {31'b0, data_data_ok}, 32'h0);
      @(negedge clk); #1;
      chk("f_data_ok_drop", {31'b0, inst_data_ok}, 32'h0);
      chk("f_rdata_hold", inst_rdata, 32'hC0DE_0100);

      // Both requesting: data first, then fetch
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h104;
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h200; #1;
      chk("b_data_addr_ok", {31'b0, data_addr_ok}, 32'h1);
      chk("b_inst_denied", {31'b0, inst_addr_ok}, 32'h0);
      chk("b_sram_addr0", sram_addr, 32'h200);
      @(negedge clk); data_req = 1'b0; #1;
      chk("b_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h1);
      chk("b_sram_addr1", sram_addr, 32'h104);
      chk("b_data_data_ok", {31'b0, data_data_ok}, 32'h1);
      chk("b_data_rdata", data_rdata, 32'hC0DE_0200);
      chk("b_inst_not_yet", {31'b0, inst_data_ok}, 32'h0);
      @(negedge clk); idle(); #1;
      chk("b_inst_data_ok", {31'b0, inst_data_ok}, 32'h1);
      chk("b_inst_rdata", inst_rdata, 32'hC0DE_0104);
      chk("b_dd_ok_drop", {31'b0, data_data_ok}, 32'h0);
      chk("b_data_rdata_hold", data_rdata, 32'hC0DE_0200);

      // Store with partial byte enables, then read back
      @(negedge clk);
      data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h300; data_wdata = 32'hDEAD_BEEF; #1;
      chk("s_addr_ok", {31'b0, data_addr_ok}, 32'h1);
      chk("s_sram_wen", {28'b0, sram_wen}, 32'h3);
      chk("s_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
      chk("s_sram_addr", sram_addr, 32'h300);
      @(negedge clk); idle(); #1;
      chk("s_data_ok", {31'b0, data_data_ok}, 32'h1);
      chk("s_no_inst_ok", {31'b0, inst_data_ok}, 32'h0);
      @(negedge clk); data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h300; #1;
      chk("s_rd_wen0", {28'b0, sram_wen}, 32'h0);
      @(negedge clk); idle(); #1;
      chk("s_readback", data_rdata, 32'hC0DE_BEEF);

      // Starvation: fetch forced on the 5th denied-in-a-row cycle, data resumes after
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         inst_req = 1'b1; inst_addr = 32'h108;
         data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h200; #1;
         chk($sformatf("st_inst_ok_%0d", c), {31'b0, inst_addr_ok}, (c == 4 || c == 9) ? 32'h1 : 32'h0);
         chk($sformatf("st_data_ok_%0d", c), {31'b0, data_addr_ok}, (c == 4 || c == 9) ? 32'h0 : 32'h1);
      end
      @(negedge clk); idle(); #1;
      chk("st_last_inst_resp", {31'b0, inst_data_ok}, 32'h1);
      chk("st_last_inst_rdata", inst_rdata, 32'hC0DE_0108);
      chk("st_no_data_resp", {31'b0, data_data_ok}, 32'h0);

      // Streaming fetch: one grant and one response every cycle, in order
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         inst_req = (i < 8); inst_addr = 32'h500 + 32'(4 * i); #1;
         chk($sformatf("sm_addr_ok_%0d", i), {31'b0, inst_addr_ok}, (i < 8) ? 32'h1 : 32'h0);
         if (i > 0) begin
            chk($sformatf("sm_data_ok_%0d", i), {31'b0, inst_data_ok}, 32'h1);
            chk($sformatf("sm_rdata_%0d", i), inst_rdata, 32'hC0DE_0000 | (32'h500 + 32'(4 * (i - 1))));
         end
      end
      @(negedge clk); idle(); #1;
      chk("sm_done", {31'b0, inst_data_ok}, 32'h0);

      // Reset asserted the cycle after a grant: response discarded
      @(negedge clk); inst_req = 1'b1; inst_addr = 32'h10; #1;
      chk("r_grant", {31'b0, inst_addr_ok}, 32'h1);
      @(negedge clk); resetn = 1'b1; #1;
      chk("r_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
      chk("r_sram_en", {31'b0, sram_en}, 32'h0);
      chk("r_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
      chk("r_inst_rdata", inst_rdata, 32'h0);
      chk("r_sram_addr", sram_addr, 32'h0);
      @(negedge clk); idle(); resetn = 1'b0; #1;
      chk("r_post_inst_ok", {31'b0, inst_data_ok}, 32'h0);
      chk("r_post_data_ok", {31'b0, data_data_ok}, 32'h0);
      @(negedge clk); #1;
      chk("r_post2_inst_ok", {31'b0, inst_data_ok}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
